// File: rtl/input_decoder_pkg.sv
// Shared types and field positions for the command RAM reader.
// Opcodes, FSM states and per-opcode operand counts.
package input_decoder_pkg;

    typedef enum logic [3:0] {
        OPC_LINE  = 4'h1,
        OPC_CLEAR = 4'h2,
        OPC_RECT  = 4'h3,
        OPC_END   = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_H  = 3'd1,
        S_CAP_H    = 3'd2,
        S_FETCH_OP = 3'd3,
        S_CAP_OP   = 3'd4,
        S_PRESENT  = 3'd5
    } state_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int COLOR_W = 24;
    localparam int X_MSB   = 25;
    localparam int X_LSB   = 16;
    localparam int Y_MSB   = 8;
    localparam int Y_LSB   = 0;
    localparam int X_W     = X_MSB - X_LSB + 1;
    localparam int Y_W     = Y_MSB - Y_LSB + 1;

    // Operand words following a header; zero for header-only opcodes.
    function automatic logic [1:0] op_words(input logic [3:0] op);
        case (op)
            OPC_LINE, OPC_RECT: op_words = 2'd2;
            default:            op_words = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/input_decoder_rdptr.sv
// Read pointer for the command RAM ring.
// Wraps at DEPTH-1, flags empty, reloads from the writer on flush.
module input_decoder_rdptr #(
    parameter int DEPTH = 400,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [AW-1:0] wr_ptr,
    input  logic          flush,
    input  logic          adv,
    output logic [AW-1:0] rd_ptr,
    output logic          empty
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    assign empty = (rd_ptr == wr_ptr);

    // Flush resyncs to the writer; otherwise step with wrap on a fetch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (adv) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/input_decoder_fetch.sv
// Fetches header/operand words from the command RAM and assembles
// one draw command per packet, presented with valid/ready.
module input_decoder_fetch
    import input_decoder_pkg::*;
#(
    parameter int DEPTH = 400,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [AW-1:0]      wr_ptr,
    input  logic               flush,
    input  logic [DW-1:0]      ram_q,
    output logic [AW-1:0]      ram_read_address,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [3:0]         cmd_opcode,
    output logic [COLOR_W-1:0] cmd_color,
    output logic [X_W-1:0]     cmd_x0,
    output logic [X_W-1:0]     cmd_x1,
    output logic [Y_W-1:0]     cmd_y0,
    output logic [Y_W-1:0]     cmd_y1,
    output logic               busy,
    output logic               error
);

    state_t        state;
    logic          op_idx;
    logic          empty;
    logic          adv;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    hdr_op;
    logic          unused_bits;

    assign hdr_op      = ram_q[OP_MSB:OP_LSB];
    assign unused_bits = ^ram_q[OP_LSB-1:X_MSB+1];

    // The RAM samples rd_ptr on the same edge that the pointer steps.
    assign adv = !flush && !empty &&
                 (state == S_FETCH_H || state == S_FETCH_OP);

    assign ram_read_address = rd_ptr;

    input_decoder_rdptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rdptr (
        .clk    (clk),
        .n_rst  (n_rst),
        .wr_ptr (wr_ptr),
        .flush  (flush),
        .adv    (adv),
        .rd_ptr (rd_ptr),
        .empty  (empty)
    );

    // Packet FSM with registered command fields and status.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            op_idx     <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_color  <= '0;
            cmd_x0     <= '0;
            cmd_y0     <= '0;
            cmd_x1     <= '0;
            cmd_y1     <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            op_idx    <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty && !error) begin
                        state <= S_FETCH_H;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH_H: begin
                    if (!empty) state <= S_CAP_H;
                end
                S_CAP_H: begin
                    unique case (1'b1)
                        (op_words(hdr_op) != 2'd0): begin
                            cmd_opcode <= hdr_op;
                            cmd_color  <= ram_q[COLOR_W-1:0];
                            op_idx     <= 1'b0;
                            state      <= S_FETCH_OP;
                        end
                        (hdr_op == OPC_CLEAR): begin
                            cmd_opcode <= hdr_op;
                            cmd_color  <= ram_q[COLOR_W-1:0];
                            cmd_x0     <= '0;
                            cmd_y0     <= '0;
                            cmd_x1     <= '0;
                            cmd_y1     <= '0;
                            cmd_valid  <= 1'b1;
                            state      <= S_PRESENT;
                        end
                        (hdr_op == OPC_END): begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            error <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
                S_FETCH_OP: begin
                    if (!empty) state <= S_CAP_OP;
                end
                S_CAP_OP: begin
                    if (!op_idx) begin
                        cmd_x0 <= ram_q[X_MSB:X_LSB];
                        cmd_y0 <= ram_q[Y_MSB:Y_LSB];
                        op_idx <= 1'b1;
                        state  <= S_FETCH_OP;
                    end else begin
                        cmd_x1    <= ram_q[X_MSB:X_LSB];
                        cmd_y1    <= ram_q[Y_MSB:Y_LSB];
                        cmd_valid <= 1'b1;
                        state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (!empty) begin
                            state <= S_FETCH_H;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
